mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU presents a load/store request.
REQ-005 req_ready  output  1  unit accepts a request; transfer when req_valid && req_ready.
REQ-006 mem_write  input  1  1 = store, 0 = load.
REQ-007 mode  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 sign_ext  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-009 addr  input  ADDR_W  byte address.
REQ-010 wdata  input  32  store data; byte/half taken from low bits.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  load result, valid with rsp_valid.
REQ-013 misalign  output  1  request misaligned, valid with rsp_valid.
REQ-014 ram_addr  output  ADDR_W-2  word address to the RAM.
REQ-015 ram_we  output  1  RAM word write strobe.
REQ-016 ram_wdata  output  32  RAM write word.
REQ-017 ram_rdata  input  32  RAM read word; valid one cycle after ram_addr is driven with ram_we=0.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPT, MERGE, WRITE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; the request is registered on acceptance.
REQ-020 Load: IDLE->READ->CAPT->RESP; rsp_valid at accept cycle T+3.
REQ-021 Word store: IDLE->WRITE->RESP; rsp_valid at T+2, no RAM read.
REQ-022 Byte/half store (read-modify-write): IDLE->READ->MERGE->WRITE->RESP; rsp_valid at T+4; unaddressed lanes keep their RAM contents.
REQ-023 Lanes are little-endian: byte n = bits 8n+7:8n, n = addr[1:0]; half selected by addr[1].
REQ-024 Byte/half loads SHALL extend to 32 bits per sign_ext; word loads ignore sign_ext.
REQ-025 ram_we SHALL be 1 only in WRITE, for exactly one cycle per store.
REQ-026 ram_addr = addr[ADDR_W-1:2] in READ, CAPT, MERGE and WRITE.
REQ-027 rdata SHALL be 0 for stores and holds its last value outside RESP.
REQ-028 rsp_valid has no backpressure; the CPU stalls until it sees rsp_valid.
REQ-029 RESP SHALL always return to IDLE; a new request can be accepted the cycle after RESP.

Reset
REQ-030 On rst: state IDLE, req_ready 1, rsp_valid 0, rdata 0, misalign 0, ram_addr 0, ram_we 0, ram_wdata 0.
REQ-031 Reset mid-operation SHALL abandon the request: no rsp_valid, and no ram_we from the cycle after the reset edge.

Configuration
REQ-032 Macro MAU_MISALIGN_TRAP_EN defined: a half with addr[0]=1 or a word with addr[1:0]!=0 goes IDLE->RESP with misalign=1, rdata=0 and no RAM access.
REQ-033 Macro not defined: misalign tied 0; ignored low address bits force alignment.

Structure
REQ-034 Package mau_pkg SHALL hold the mode encodings (MODE_BYTE/HALF/WORD) and the FSM state enum.
REQ-035 Sub-module mau_lane (combinational) SHALL perform load extract/extend and store merge; the FSM and registers live in mem_access_unit.

Verification
REQ-036 RAM[0]=0x8899AABB; LB addr 0x2, sign_ext=1 -> rdata 0xFFFFFF99 at T+3; LBU -> 0x00000099.
REQ-037 RAM[1]=0x11223344; SH addr 0x6, wdata 0x0000BEEF -> one ram_we, ram_wdata 0xBEEF3344 at word 1, rsp_valid at T+4.
REQ-038 SW addr 0x8, wdata 0xDEADBEEF -> no read cycle, ram_we at T+1, rsp_valid at T+2; a following LW returns 0xDEADBEEF.
REQ-039 MAU_MISALIGN_TRAP_EN defined, LW addr 0x3 -> rsp_valid at T+1 with misalign=1, ram_we never 1; not defined -> reads word 0, misalign 0.
REQ-040 rst asserted during MERGE of an SB -> ram_we stays 0, no rsp_valid, req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/mau_pkg.sv
// Memory access unit shared types: access modes, FSM states, request bundle.
// Build option: MAU_MISALIGN_TRAP_EN enables the misaligned-access trap.
package mau_pkg;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CAPT  = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    CAPT  = ST_CAPT,
    MERGE = ST_MERGE,
    WRITE = ST_WRITE,
    RESP  = ST_RESP
  } mau_state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  mode;
    logic        sign_ext;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } mau_req_t;

  // Mode 11 is treated as a word access.
  function automatic logic is_word(
    input logic [1:0] mode
  );
    return mode[1];
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] mode,
    input logic [1:0] lo
  );
    logic mis;
    mis = 1'b0;
    unique case (1'b1)
      (mode == MODE_BYTE): mis = 1'b0;
      (mode == MODE_HALF): mis = lo[0];
      default:             mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Lane steering for the memory access unit:
// load extract/extend and store read-modify-write merge.
module mau_lane
  import mau_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_msb;
  logic        half_msb;

  // Pick the addressed byte and half out of the RAM word.
  always_comb begin
    byte_sel = ram_word[7:0];
    unique case (lane)
      2'd0: byte_sel = ram_word[7:0];
      2'd1: byte_sel = ram_word[15:8];
      2'd2: byte_sel = ram_word[23:16];
      2'd3: byte_sel = ram_word[31:24];
      default: byte_sel = ram_word[7:0];
    endcase
    half_sel = lane[1] ? ram_word[31:16]
                       : ram_word[15:0];
  end

  assign byte_msb = sign_ext & byte_sel[7];
  assign half_msb = sign_ext & half_sel[15];

  // Extend sub-word loads; words pass through.
  always_comb begin
    load_data = ram_word;
    unique case (1'b1)
      (mode == MODE_BYTE):
        load_data = {{24{byte_msb}}, byte_sel};
      (mode == MODE_HALF):
        load_data = {{16{half_msb}}, half_sel};
      default:
        load_data = ram_word;
    endcase
  end

  // Overlay store data onto the addressed lanes only.
  always_comb begin
    merge_data = ram_word;
    unique case (1'b1)
      (mode == MODE_BYTE):
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      (mode == MODE_HALF):
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default:
        merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between CPU and a one-cycle-latency word RAM.
// Build option: MAU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_write,
  input  logic [1:0]        mode,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mau_state_e        state;
  mau_req_t          req_q;
  logic [ADDR_W-3:0] word_q;
  logic [31:0]       wword_q;
  logic [31:0]       rdata_q;
  logic              mis_req;
  logic              accept;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign accept = req_valid && (state == IDLE);

`ifdef MAU_MISALIGN_TRAP_EN
  logic mis_q;

  assign mis_req  = is_misaligned(mode, addr[1:0]);
  assign misalign = mis_q;

  // Latch the trap flag with the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= mis_req;
    end
  end
`else
  assign mis_req  = 1'b0;
  assign misalign = 1'b0;
`endif

  mau_lane u_lane (
    .mode       (req_q.mode),
    .sign_ext   (req_q.sign_ext),
    .lane       (req_q.lane),
    .ram_word   (ram_rdata),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Access sequencer: request capture, RAM read/merge/write, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      word_q  <= '0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_q.write    <= mem_write;
            req_q.mode     <= mode;
            req_q.sign_ext <= sign_ext;
            req_q.lane     <= addr[1:0];
            req_q.wdata    <= wdata;
            word_q         <= addr[ADDR_W-1:2];
            wword_q        <= wdata;
            if (mis_req) begin
              rdata_q <= '0;
              state   <= RESP;
            end else if (mem_write
                         && is_word(mode)) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state <= req_q.write ? MERGE : CAPT;
        end
        CAPT: begin
          rdata_q <= load_data;
          state   <= RESP;
        end
        MERGE: begin
          wword_q <= merge_data;
          state   <= WRITE;
        end
        WRITE: begin
          rdata_q <= '0;
          state   <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rdata     = rdata_q;
  assign ram_addr  = word_q;
  assign ram_we    = (state == WRITE);
  assign ram_wdata = wword_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small word RAM.
// Expectations follow MAU_MISALIGN_TRAP_EN when it is defined.
module tb_mem_access_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          mem_write;
  logic [1:0]    mode;
  logic          sign_ext;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          rsp_valid;
  logic [31:0]   rdata;
  logic          misalign;
  logic [AW-3:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          nwe;
    int          we_lat;
    logic [31:0] wword;
    int          waddr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[16];
  logic [31:0] shadow[16];
  logic [31:0] last_rd;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_write (mem_write),
    .mode      (mode),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .misalign  (misalign),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h8899AABB;
    if (i == 1) return 32'h11223344;
    return 32'hA5000000 | (32'(i) * 32'h00010203);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (ram_we) begin
      mem[ram_addr[3:0]] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr[3:0]];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reinit_shadow();
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
  endtask

  task automatic model(input logic wr, input logic [1:0] md,
                       input logic sx, input logic [5:0] a,
                       input logic [31:0] wd);
    exp_t        e;
    logic [31:0] w;
    logic [31:0] sh;
    logic [31:0] mask;
    logic        mis;
    int          lo;
    w   = shadow[a[5:2]];
    lo  = int'(a[1:0]);
    mis = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    if (md == 2'b01 && a[0]) mis = 1'b1;
    if (md[1] && a[1:0] != 2'b00) mis = 1'b1;
`endif
    e.mis    = mis;
    e.waddr  = int'(a[5:2]);
    e.nwe    = 0;
    e.we_lat = 0;
    e.wword  = 32'h0;
    e.rdata  = 32'h0;
    e.lat    = 1;
    if (!mis && !wr) begin
      e.lat = 3;
      case (md)
        2'b00: begin
          sh = w >> (8 * lo);
          e.rdata = sh & 32'hFF;
          if (sx && sh[7]) e.rdata |= 32'hFFFFFF00;
        end
        2'b01: begin
          sh = w >> (16 * (lo / 2));
          e.rdata = sh & 32'hFFFF;
          if (sx && sh[15]) e.rdata |= 32'hFFFF0000;
        end
        default: e.rdata = w;
      endcase
    end else if (!mis) begin
      e.nwe = 1;
      if (md[1]) begin
        e.lat    = 2;
        e.we_lat = 1;
        e.wword  = wd;
      end else begin
        e.lat    = 4;
        e.we_lat = 3;
        mask = (md == 2'b00) ? 32'hFF : 32'hFFFF;
        if (md == 2'b01) lo = lo & 2;
        mask = mask << (8 * lo);
        e.wword = (w & ~mask) | ((wd << (8 * lo)) & mask);
      end
      shadow[a[5:2]] = e.wword;
    end
    sb.push_back(e);
  endtask

  task automatic run(input logic wr, input logic [1:0] md,
                     input logic sx, input logic [5:0] a,
                     input logic [31:0] wd);
    exp_t        e;
    int          t0;
    int          nwe;
    int          we_at;
    logic [31:0] wa;
    logic [31:0] wdw;
    bit          got;
    @(negedge clk);
    chk("ready", 32'(req_ready), 32'h1);
    chk("rdata_hold", rdata, last_rd);
    req_valid = 1'b1;
    mem_write = wr;
    mode      = md;
    sign_ext  = sx;
    addr      = {26'b0, a};
    wdata     = wd;
    model(wr, md, sx, a, wd);
    t0    = cyc;
    nwe   = 0;
    we_at = -1;
    wa    = 32'h0;
    wdw   = 32'h0;
    got   = 1'b0;
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ram_we) begin
        nwe++;
        we_at = n;
        wa    = 32'(ram_addr);
        wdw   = ram_wdata;
      end
      if (rsp_valid) begin
        got = 1'b1;
        e = sb.pop_front();
        last_rd = rdata;
        chk("latency", 32'(cyc - t0), 32'(e.lat));
        chk("rdata", rdata, e.rdata);
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("we_count", 32'(nwe), 32'(e.nwe));
        if (e.nwe > 0) begin
          chk("we_cycle", 32'(we_at), 32'(e.we_lat));
          chk("ram_wdata", wdw, e.wword);
          chk("ram_addr", wa, 32'(e.waddr));
        end
      end
    end
    if (!got) begin
      chk("rsp_timeout", 32'h0, 32'h1);
      e = sb.pop_front();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    mem_write = 1'b0;
    mode      = 2'b00;
    sign_ext  = 1'b0;
    addr      = '0;
    wdata     = 32'h0;
    last_rd   = 32'h0;
    reinit_shadow();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    rst = 1'b0;

    run(1'b0, 2'b00, 1'b1, 6'h02, 32'h0);
    run(1'b0, 2'b00, 1'b0, 6'h02, 32'h0);
    run(1'b1, 2'b01, 1'b0, 6'h06, 32'h0000BEEF);
    run(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
    run(1'b1, 2'b10, 1'b0, 6'h08, 32'hDEADBEEF);
    run(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    run(1'b0, 2'b01, 1'b1, 6'h02, 32'h0);
    run(1'b0, 2'b01, 1'b0, 6'h00, 32'h0);
    run(1'b1, 2'b00, 1'b0, 6'h0D, 32'hFFFFFF55);
    run(1'b0, 2'b11, 1'b1, 6'h0C, 32'h0);
    run(1'b0, 2'b10, 1'b0, 6'h03, 32'h0);
    run(1'b1, 2'b01, 1'b0, 6'h05, 32'h0000CAFE);

    for (int i = 0; i < 40; i++) begin
      run(1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          6'($urandom_range(0, 63)),
          $urandom);
    end

    @(negedge clk);
    req_valid = 1'b1;
    mem_write = 1'b1;
    mode      = 2'b00;
    sign_ext  = 1'b0;
    addr      = 32'h5;
    wdata     = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("merge_we", 32'(ram_we), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_we", 32'(ram_we), 32'h0);
    chk("abort_rsp", 32'(rsp_valid), 32'h0);
    chk("abort_ready", 32'(req_ready), 32'h1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_idle_we", 32'(ram_we), 32'h0);
      chk("abort_idle_rsp", 32'(rsp_valid), 32'h0);
    end
    reinit_shadow();
    last_rd = 32'h0;
    run(1'b0, 2'b00, 1'b0, 6'h05, 32'h0);
    run(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
